spram_fifo_ctrl: RTL

Controller that sequences a single-port RAM (SPRAM) as a synchronous FIFO.
- Arbitrates independent push and pop requesters for the RAM's single access slot: at most one read or one write per cycle.
- Owns the read/write pointers, the occupancy count and the full/empty flags.
- Sits between the instruction decoder and the SPRAM macro, replacing ad-hoc WE/RE sequencing.

---
 rtl/spram_fifo_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl: single-port RAM FIFO sequencer with round-robin push/pop arbitration; FIFO_ERR_CNT_EN adds saturating overflow/underflow counters
module spram_fifo_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FIFO_ERR_CNT_EN
    ,
    output logic [7:0]        ovf_cnt,
    output logic [7:0]        udf_cnt
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {WR, RD} prio_t;
    prio_t prio, prio_nxt;
    logic [ADDR_W-1:0] wptr, rptr;
    logic [ADDR_W:0] count_nxt;
    logic wr_elig, rd_elig, wr_fire, rd_fire, vld;
    always_comb begin
        wr_elig   = wr_valid && !full;
        rd_elig   = rd_req && !empty;
        wr_ready  = !full && (!rd_elig || prio == WR);
        rd_ready  = !empty && (!wr_elig || prio == RD);
        wr_fire   = wr_valid && wr_ready;
        rd_fire   = rd_req && rd_ready;
        mem_en    = wr_fire || rd_fire;
        mem_we    = wr_fire;
        mem_addr  = wr_fire ? wptr : rptr;
        mem_wdata = wr_data;
        rd_data   = mem_rdata;
        count_nxt = count + (ADDR_W+1)'(wr_fire) - (ADDR_W+1)'(rd_fire);
        prio_nxt  = (wr_elig && rd_elig) ? (wr_fire ? RD : WR) : prio;
    end
    // a read launched just before reset must not surface while reset is held
    assign rd_data_valid = vld && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            prio  <= WR;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            vld   <= 1'b0;
        end else begin
            prio  <= prio_nxt;
            wptr  <= wptr + ADDR_W'(wr_fire);
            rptr  <= rptr + ADDR_W'(rd_fire);
            count <= count_nxt;
            empty <= count_nxt == '0;
            full  <= count_nxt == (ADDR_W+1)'(DEPTH);
            vld   <= rd_fire;
        end
    end
`ifdef FIFO_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            ovf_cnt <= ovf_cnt + 8'(wr_valid && full && ovf_cnt != 8'hFF);
            udf_cnt <= udf_cnt + 8'(rd_req && empty && udf_cnt != 8'hFF);
        end
    end
`endif
endmodule
